// File: rtl/nand_from_basic_unit.sv
// nand_from_basic_unit
// Registered NAND/AND/NOT primitive that sits between two valid/ready
// streams. The AND stage feeds a NOT stage, so the NAND result is always
// the inverse of the AND-stage output rather than an independent gate.
//
// Optional build macro: STAGE_REG_EN
//   undefined : one register slot, 1-cycle latency,
//               in_ready = !out_valid | out_ready
//   defined   : extra register between the AND and NOT stages, 2-cycle
//               latency, 2-entry chain with per-stage valid bits
// Results are identical in both builds; only latency and buffering differ.
module nand_from_basic_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_nand,
    output logic             illegal_op
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NOTA = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // NOT stage: plain bitwise inversion, shared by the NAND path and NOT(a).
    function automatic logic [WIDTH-1:0] not_stage(input logic [WIDTH-1:0] v);
        return ~v;
    endfunction

    // Result select; the reserved code behaves like NAND.
    function automatic logic [WIDTH-1:0] sel_result(
        input logic [1:0]       op_v,
        input logic [WIDTH-1:0] and_v,
        input logic [WIDTH-1:0] not_a_v,
        input logic [WIDTH-1:0] nand_v
    );
        logic [WIDTH-1:0] r;
        case (op_v)
            OP_AND:  r = and_v;
            OP_NOTA: r = not_a_v;
            OP_NAND: r = nand_v;
            default: r = nand_v;
        endcase
        return r;
    endfunction

    logic             accept;
    logic [WIDTH-1:0] and_p0;
    logic [WIDTH-1:0] not_a_p0;

    assign accept   = in_valid & in_ready;
    assign and_p0   = a & b;
    assign not_a_p0 = not_stage(a);

    // Sticky illegal-op flag: set by an accepted reserved opcode, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (accept && (op == OP_RSVD)) begin
            illegal_op <= 1'b1;
        end
    end

`ifdef STAGE_REG_EN

    // ---- stage 1: registered AND result, NOT(a) and op
    logic             vld_p1;
    logic [WIDTH-1:0] and_p1;
    logic [WIDTH-1:0] not_a_p1;
    logic [1:0]       op_p1;
    logic [WIDTH-1:0] nand_p1;

    // ---- stage 2: output register
    logic             vld_p2;
    logic [WIDTH-1:0] y_p2;
    logic [WIDTH-1:0] and_p2;
    logic [WIDTH-1:0] nand_p2;
    logic             adv_p2;

    // Output stage takes a new beat when it is empty or being drained.
    assign adv_p2   = !vld_p2 | out_ready;
    // Stage 1 accepts when it is empty or its beat moves on this cycle.
    assign in_ready = !vld_p1 | adv_p2;
    assign nand_p1  = not_stage(and_p1);

    // Stage 1 register: captures the AND-stage output on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            and_p1   <= '0;
            not_a_p1 <= '0;
            op_p1    <= '0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                and_p1   <= and_p0;
                not_a_p1 <= not_a_p0;
                op_p1    <= op;
            end
        end
    end

    // Stage 2 register: NOT stage result and final select; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            y_p2    <= '0;
            and_p2  <= '0;
            nand_p2 <= '0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                and_p2  <= and_p1;
                nand_p2 <= nand_p1;
                y_p2    <= sel_result(op_p1, and_p1, not_a_p1, nand_p1);
            end
        end
    end

    assign out_valid = vld_p2;
    assign y         = y_p2;
    assign y_and     = and_p2;
    assign y_nand    = nand_p2;

`else

    // ---- stage 1: single output register slot
    logic             vld_p1;
    logic [WIDTH-1:0] y_p1;
    logic [WIDTH-1:0] and_p1;
    logic [WIDTH-1:0] nand_p1;
    logic [WIDTH-1:0] nand_p0;

    assign nand_p0  = not_stage(and_p0);
    // Refill is allowed in the same cycle the held beat drains.
    assign in_ready = !vld_p1 | out_ready;

    // Output slot: load on accept, clear valid on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            y_p1    <= '0;
            and_p1  <= '0;
            nand_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            and_p1  <= and_p0;
            nand_p1 <= nand_p0;
            y_p1    <= sel_result(op, and_p0, not_a_p0, nand_p0);
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign y         = y_p1;
    assign y_and     = and_p1;
    assign y_nand    = nand_p1;

`endif

endmodule

// File: tb/tb_nand_from_basic_unit.sv
// Bench for nand_from_basic_unit (WIDTH=8): directed scenarios plus a
// randomized run against a queue-based scoreboard.
module tb_nand_from_basic_unit;

`ifdef STAGE_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic [7:0] y_and;
    logic [7:0] y_nand;
    logic       illegal_op;

    nand_from_basic_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .y_and      (y_and),
        .y_nand     (y_nand),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ry;
        logic [7:0] rand_;
        logic [7:0] rnand;
    } res_t;

    res_t       q[$];
    logic       m_ill = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] hy, hya, hyn;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: results computed straight from the operation table.
    function automatic res_t model(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] opv);
        res_t r;
        r.rand_ = av & bv;
        r.rnand = ~(av & bv);
        if (opv == 2'd0)      r.ry = av & bv;
        else if (opv == 2'd1) r.ry = ~av;
        else                  r.ry = ~(av & bv);
        return r;
    endfunction

    // One clock: sample/score at negedge, then advance to just after posedge.
    task automatic cycle();
        res_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            m_ill      = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", out_valid, 1'b1);
                chk("hold_y", y, hy);
                chk("hold_and", y_and, hya);
                chk("hold_nand", y_nand, hyn);
            end
            chk("illegal", illegal_op, m_ill);
`ifndef STAGE_REG_EN
            chk("in_ready", in_ready, (!out_valid) | out_ready);
`endif
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("sb_y", y, e.ry);
                    chk("sb_and", y_and, e.rand_);
                    chk("sb_nand", y_nand, e.rnand);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, op));
                if (op == 2'd3) m_ill = 1'b1;
            end
            stall_prev = out_valid && !out_ready;
            hy  = y;
            hya = y_and;
            hyn = y_nand;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_y", y, 8'h00);
        chk("rst_and", y_and, 8'h00);
        chk("rst_nand", y_nand, 8'h00);
        chk("rst_ill", illegal_op, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);
    endtask

    // Send one beat into an empty unit and measure accept-to-valid latency.
    task automatic send_one(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] opv);
        int lat;
        a = av; b = bv; op = opv; in_valid = 1'b1;
        #1;
        chk("send_rdy", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            cycle();
            lat++;
        end
        chk("latency", lat, LAT);
    endtask

    logic [7:0] tt_y   [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] tt_and [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};

    initial begin
        int n;
        // Reset state
        do_reset();
        check_reset_state();

        // Truth table (each lane is a 1-bit NAND), op=10
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_one((i & 2) != 0 ? 8'hFF : 8'h00, (i & 1) != 0 ? 8'hFF : 8'h00, 2'b10);
            chk("tt_y", y, tt_y[i]);
            chk("tt_and", y_and, tt_and[i]);
            cycle();
        end

        // op=00 and op=01 on wider patterns
        send_one(8'hA5, 8'h0F, 2'b00);
        chk("and_y", y, 8'h05);
        chk("and_nand", y_nand, 8'hFA);
        cycle();
        send_one(8'hA5, 8'h3C, 2'b01);
        chk("nota_y", y, 8'h5A);
        cycle();

        // Backpressure: hold out_ready low while new beats wait
        out_ready = 1'b0;
        send_one(8'hF0, 8'h3C, 2'b10);
        a = 8'h12; b = 8'h34; op = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_rdy", in_ready, 1'b0);
        chk("bp_y", y, 8'hCF);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a = 8'(i * 37 + 5); b = 8'(i * 11 + 200); op = 2'(i % 3);
            #1;
            chk("b2b_rdy", in_ready, 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("bp_drain", q.size(), 0);

        // Reserved opcode: sticky flag
        send_one(8'hFF, 8'hFF, 2'b11);
        chk("rsvd_y", y, 8'h00);
        cycle();
        chk("rsvd_ill", illegal_op, 1'b1);
        send_one(8'h0F, 8'hFF, 2'b00);
        cycle();
        chk("ill_sticky", illegal_op, 1'b1);

        // Reset while a beat is stalled at the output
        out_ready = 1'b0;
        send_one(8'h77, 8'h33, 2'b10);
        a = 8'h55; in_valid = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset_state();

        // Randomized run against the scoreboard
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 2'($urandom_range(0, 3));
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("final_drain", q.size(), 0);
        cycle();
        chk("final_vld", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
